mcu_control_seq: RTL and testbench

Multi-cycle control sequencer for the 8-register MCU datapath. It fetches 16-bit instructions from program memory over a req/ack handshake and decodes them. It then drives the register file's read addresses (AA/BA), write address (DA) and write strobe (WR), plus the ALU opcode/enable and write-back mux select. It sits directly upstream of the register file and ALU and owns the program counter.

---
 rtl/mcu_control_seq_if.sv | 30 +++
 rtl/mcu_control_seq.sv | 101 ++++++++++
 tb/tb_mcu_control_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mcu_control_seq_if.sv
// Bus between the control sequencer and its program memory, register file and ALU.
interface mcu_control_seq_if #(
  parameter int PC_W = 8,
  parameter int IW   = 16
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [IW-1:0]   imem_data;
  logic [2:0]      AA;
  logic [2:0]      BA;
  logic [2:0]      DA;
  logic            WR;
  logic [3:0]      alu_op;
  logic            alu_en;
  logic            alu_zero;
  logic            wb_sel;
  logic [7:0]      imm;
  logic            halted;

  modport master (
    output imem_req, imem_addr, AA, BA, DA, WR, alu_op, alu_en, wb_sel, imm, halted,
    input  imem_ack, imem_data, alu_zero
  );

  modport slave (
    input  imem_req, imem_addr, AA, BA, DA, WR, alu_op, alu_en, wb_sel, imm, halted,
    output imem_ack, imem_data, alu_zero
  );
endinterface

// File: rtl/mcu_control_seq.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-register MCU datapath.
// Owns the program counter and drives register-file addresses, ALU strobes and write-back.
module mcu_control_seq #(
  parameter int PC_W = 8,
  parameter int IW   = 16
) (
  input logic              clk,
  input logic              rst,
  mcu_control_seq_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    READ   = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_RSVD = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt, pc_inc, target;
  logic [IW-1:0]   ir;
  logic [3:0]      op;
  logic            zflag, zflag_nxt;
  logic            active;
  logic            req, take;

  assign op     = ir[15:12];
  assign pc_inc = pc + PC_W'(1);
  assign target = PC_W'(ir[7:0]);

  // active holds off the fetch request for the cycle in which reset is still asserted
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= FETCH;
      pc     <= '0;
      ir     <= '0;
      zflag  <= 1'b0;
      active <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      zflag  <= zflag_nxt;
      active <= 1'b1;
      if (take) ir <= bus.imem_data;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    zflag_nxt = zflag;
    unique case (state)
      FETCH:  if (take) state_nxt = DECODE;
      DECODE: begin
        unique case (op)
          OP_NOP, OP_RSVD: begin pc_nxt = pc_inc; state_nxt = FETCH; end
          OP_LDI:          state_nxt = WB;
          OP_BZ:           begin pc_nxt = zflag ? target : pc_inc; state_nxt = FETCH; end
          OP_JMP:          begin pc_nxt = target; state_nxt = FETCH; end
          OP_HALT:         state_nxt = HALT;
          default:         state_nxt = READ;
        endcase
      end
      READ:   state_nxt = EXEC;
      EXEC:   state_nxt = WB;
      WB: begin
        if (op != OP_LDI) zflag_nxt = bus.alu_zero;
        pc_nxt    = pc_inc;
        state_nxt = FETCH;
      end
      HALT:   state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    req           = active && (state == FETCH);
    take          = req && bus.imem_ack;
    bus.imem_req  = req;
    bus.imem_addr = pc;
    bus.AA        = ir[8:6];
    bus.BA        = ir[5:3];
    bus.DA        = ir[11:9];
    bus.alu_op    = op;
    bus.imm       = ir[7:0];
    bus.WR        = (state == WB);
    bus.alu_en    = (state == EXEC);
    bus.wb_sel    = (op == OP_LDI);
    bus.halted    = (state == HALT);
  end

endmodule

// File: tb/tb_mcu_control_seq.sv
// Directed self-checking bench for mcu_control_seq.
module tb_mcu_control_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mcu_control_seq_if #(.PC_W(8), .IW(16)) bus ();

  mcu_control_seq #(.PC_W(8), .IW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction with zero-wait ack during a FETCH cycle; returns in DECODE.
  task automatic give(input logic [15:0] instr);
    bus.imem_data = instr;
    bus.imem_ack  = 1'b1;
    step();
    bus.imem_ack  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.imem_ack  = 1'b1;
    bus.imem_data = 16'hFFFF;
    repeat (3) step();
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
    total++; if (bus.WR !== 1'b0) begin bad++; $display("FAIL rst_wr: got %b want 0", bus.WR); end
    total++; if ({bus.AA, bus.BA, bus.DA} !== 9'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", {bus.AA, bus.BA, bus.DA}); end
    total++; if ({bus.alu_op, bus.alu_en, bus.wb_sel} !== 6'h0) begin bad++; $display("FAIL rst_alu: got %h want 0", {bus.alu_op, bus.alu_en, bus.wb_sel}); end
    total++; if ({bus.imm, bus.halted} !== 9'h0) begin bad++; $display("FAIL rst_imm_halt: got %h want 0", {bus.imm, bus.halted}); end
    bus.imem_ack = 1'b0;
    rst = 1'b1;
    step();
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL rel_req: got %b want 1", bus.imem_req); end
    total++; if (bus.imem_addr !== 8'h00) begin bad++; $display("FAIL rel_addr: got %h want 00", bus.imem_addr); end
  endtask

  task automatic test_ldi();
    give(16'h13A5);
    total++; if (bus.WR !== 1'b0) begin bad++; $display("FAIL ldi_dec_wr: got %b want 0", bus.WR); end
    step();
    total++; if (bus.WR !== 1'b1) begin bad++; $display("FAIL ldi_wr: got %b want 1", bus.WR); end
    total++; if (bus.DA !== 3'd1) begin bad++; $display("FAIL ldi_da: got %0d want 1", bus.DA); end
    total++; if (bus.wb_sel !== 1'b1) begin bad++; $display("FAIL ldi_wbsel: got %b want 1", bus.wb_sel); end
    total++; if (bus.imm !== 8'hA5) begin bad++; $display("FAIL ldi_imm: got %h want a5", bus.imm); end
    step();
    total++; if ({bus.imem_req, bus.WR} !== 2'b10) begin bad++; $display("FAIL ldi_next_req: got %b want 10", {bus.imem_req, bus.WR}); end
    total++; if (bus.imem_addr !== 8'h01) begin bad++; $display("FAIL ldi_next_addr: got %h want 01", bus.imem_addr); end
  endtask

  task automatic test_alu();
    give(16'h2650);
    step();
    total++; if ({bus.AA, bus.BA} !== {3'd1, 3'd2}) begin bad++; $display("FAIL alu_read_ab: got %h want %h", {bus.AA, bus.BA}, {3'd1, 3'd2}); end
    total++; if ({bus.WR, bus.alu_en} !== 2'b00) begin bad++; $display("FAIL alu_read_strobes: got %b want 00", {bus.WR, bus.alu_en}); end
    step();
    total++; if (bus.alu_en !== 1'b1) begin bad++; $display("FAIL alu_exec_en: got %b want 1", bus.alu_en); end
    total++; if (bus.alu_op !== 4'd2) begin bad++; $display("FAIL alu_exec_op: got %h want 2", bus.alu_op); end
    total++; if (bus.WR !== 1'b0) begin bad++; $display("FAIL alu_exec_wr: got %b want 0", bus.WR); end
    step();
    total++; if ({bus.WR, bus.alu_en, bus.wb_sel} !== 3'b100) begin bad++; $display("FAIL alu_wb_strobes: got %b want 100", {bus.WR, bus.alu_en, bus.wb_sel}); end
    total++; if (bus.DA !== 3'd3) begin bad++; $display("FAIL alu_wb_da: got %0d want 3", bus.DA); end
    step();
    total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h02}) begin bad++; $display("FAIL alu_next: got %h want 102", {bus.imem_req, bus.imem_addr}); end
  endtask

  task automatic test_wait_fetch();
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'hF000;
    for (int i = 0; i < 4; i++) begin
      total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h02}) begin bad++; $display("FAIL wait_hold%0d: got %h want 102", i, {bus.imem_req, bus.imem_addr}); end
      step();
    end
    give(16'h0000);
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL wait_dec_req: got %b want 0", bus.imem_req); end
    step();
    total++; if ({bus.imem_req, bus.imem_addr, bus.halted} !== {1'b1, 8'h03, 1'b0}) begin bad++; $display("FAIL wait_next: got %h want 206", {bus.imem_req, bus.imem_addr, bus.halted}); end
  endtask

  task automatic test_bz();
    give(16'h3000);
    repeat (3) step();
    bus.alu_zero = 1'b1;
    step();
    bus.alu_zero = 1'b0;
    total++; if (bus.imem_addr !== 8'h04) begin bad++; $display("FAIL bz_alu1_next: got %h want 04", bus.imem_addr); end
    give(16'hC040);
    step();
    total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h40}) begin bad++; $display("FAIL bz_taken: got %h want 140", {bus.imem_req, bus.imem_addr}); end
    give(16'h3000);
    repeat (4) step();
    total++; if (bus.imem_addr !== 8'h41) begin bad++; $display("FAIL bz_alu2_next: got %h want 41", bus.imem_addr); end
    give(16'hC040);
    step();
    total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h42}) begin bad++; $display("FAIL bz_not_taken: got %h want 142", {bus.imem_req, bus.imem_addr}); end
  endtask

  task automatic test_jmp_wrap();
    give(16'hD0FF);
    step();
    total++; if (bus.imem_addr !== 8'hFF) begin bad++; $display("FAIL jmp_target: got %h want ff", bus.imem_addr); end
    give(16'h0000);
    step();
    total++; if (bus.imem_addr !== 8'h00) begin bad++; $display("FAIL pc_wrap: got %h want 00", bus.imem_addr); end
    give(16'hE123);
    total++; if (bus.WR !== 1'b0) begin bad++; $display("FAIL rsvd_wr: got %b want 0", bus.WR); end
    step();
    total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h01}) begin bad++; $display("FAIL rsvd_next: got %h want 101", {bus.imem_req, bus.imem_addr}); end
  endtask

  task automatic test_halt();
    give(16'hF000);
    step();
    total++; if ({bus.halted, bus.imem_req} !== 2'b10) begin bad++; $display("FAIL halt_enter: got %b want 10", {bus.halted, bus.imem_req}); end
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if ({bus.halted, bus.imem_req, bus.WR} !== 3'b100) begin bad++; $display("FAIL halt_stay%0d: got %b want 100", i, {bus.halted, bus.imem_req, bus.WR}); end
    end
    bus.imem_ack = 1'b0;
  endtask

  task automatic test_reset_wb();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    total++; if ({bus.imem_req, bus.imem_addr, bus.halted} !== {1'b1, 8'h00, 1'b0}) begin bad++; $display("FAIL rst2_release: got %h want 200", {bus.imem_req, bus.imem_addr, bus.halted}); end
    give(16'h2650);
    repeat (3) step();
    total++; if (bus.WR !== 1'b1) begin bad++; $display("FAIL rstwb_wr_before: got %b want 1", bus.WR); end
    rst = 1'b0;
    step();
    total++; if ({bus.WR, bus.imem_req, bus.DA} !== 5'b0) begin bad++; $display("FAIL rstwb_suppress: got %b want 00000", {bus.WR, bus.imem_req, bus.DA}); end
    rst = 1'b1;
    step();
    total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h00}) begin bad++; $display("FAIL rstwb_pc: got %h want 100", {bus.imem_req, bus.imem_addr}); end
  endtask

  initial begin
    bus.imem_ack  = 1'b0;
    bus.imem_data = '0;
    bus.alu_zero  = 1'b0;
    test_reset();
    test_ldi();
    test_alu();
    test_wait_fetch();
    test_bz();
    test_jmp_wrap();
    test_halt();
    test_reset_wb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
